// File: rtl/cs_subtractor_pipe.sv
// cs_subtractor_pipe
//   Pipelined carry-skip subtractor: D = A - B - BIN, one BLOCK-bit slice per
//   pipeline stage. Each slice resolves its borrow-out through a skip mux.
//   If the slice operands are equal, the borrow-in passes straight through.
//   Otherwise the borrow-out is the slice compare (A_k < B_k).
//
// Parameters
//   WIDTH   operand/result width, a multiple of BLOCK (default 8)
//   BLOCK   slice width, one slice per stage (default 4)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands presented          in_ready   operands accepted this cycle
//   A, B, BIN  minuend, subtrahend, borrow-in
//   out_valid  result valid                out_ready  consumer takes result
//   D, BOUT    difference, borrow-out (1 = unsigned A < B + BIN)
//   OVF        signed overflow, present only when CS_SUB_OVF_EN is defined
//
// Optional feature macro: CS_SUB_OVF_EN (adds the registered OVF output).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data stable while valid is high and ready is
// low. ready never waits on valid. in_ready is combinational from pipeline
// occupancy and out_ready only.
module cs_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT
`ifdef CS_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int NSTAGES = WIDTH / BLOCK;

  // Stage registers. d_r[k] holds the result slices 0..k. a_r/b_r[k] hold only
  // the operand slices above k. Consumed slices are written as zero, so they
  // are never carried forward.
  logic [NSTAGES-1:0] v_r;
  logic [NSTAGES-1:0] bout_r;
  logic [WIDTH-1:0]   d_r [NSTAGES];
  logic [WIDTH-1:0]   a_r [NSTAGES];
  logic [WIDTH-1:0]   b_r [NSTAGES];

  // go[k]: stage k loads this cycle (it is empty, or its contents move on).
  // go[NSTAGES] is the consumer side.
  logic [NSTAGES:0]   go;

  // Stage inputs: the external operands for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0]   src_a [NSTAGES];
  logic [WIDTH-1:0]   src_b [NSTAGES];
  logic [WIDTH-1:0]   src_d [NSTAGES];
  logic [NSTAGES-1:0] src_v;
  logic [NSTAGES-1:0] src_bin;

  logic [WIDTH-1:0]   nxt_d [NSTAGES];
  logic [WIDTH-1:0]   nxt_a [NSTAGES];
  logic [WIDTH-1:0]   nxt_b [NSTAGES];
  logic [NSTAGES-1:0] nxt_bout;
  logic               nxt_ovf;

  always_comb begin
    go = '0;
    go[NSTAGES] = out_ready;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      go[k] = !v_r[k] || go[k+1];
    end
  end

  assign in_ready = go[0];

  always_comb begin
    logic [BLOCK-1:0] as_t;
    logic [BLOCK-1:0] bs_t;
    logic [BLOCK-1:0] diff_t;
    logic [WIDTH-1:0] keep_mask;

    src_a[0]   = A;
    src_b[0]   = B;
    src_d[0]   = '0;
    src_v[0]   = in_valid;
    src_bin[0] = BIN;
    for (int k = 1; k < NSTAGES; k++) begin
      src_a[k]   = a_r[k-1];
      src_b[k]   = b_r[k-1];
      src_d[k]   = d_r[k-1];
      src_v[k]   = v_r[k-1];
      src_bin[k] = bout_r[k-1];
    end

    nxt_ovf = 1'b0;
    for (int k = 0; k < NSTAGES; k++) begin
      as_t   = src_a[k][k*BLOCK +: BLOCK];
      bs_t   = src_b[k][k*BLOCK +: BLOCK];
      diff_t = as_t - bs_t - {{(BLOCK-1){1'b0}}, src_bin[k]};
      // Borrow-skip: equal slices cannot generate or absorb a borrow.
      nxt_bout[k] = (as_t == bs_t) ? src_bin[k] : (as_t < bs_t);

      nxt_d[k] = src_d[k];
      nxt_d[k][k*BLOCK +: BLOCK] = diff_t;

      // Drop slices 0..k of the operands. The last stage keeps nothing.
      keep_mask = {WIDTH{1'b1}} << ((k + 1) * BLOCK);
      nxt_a[k]  = src_a[k] & keep_mask;
      nxt_b[k]  = src_b[k] & keep_mask;

      // The top slice carries the operand sign bits. Overflow occurs when the
      // signs differ and the result sign differs from the minuend sign.
      if (k == NSTAGES - 1) begin
        nxt_ovf = (as_t[BLOCK-1] ^ bs_t[BLOCK-1]) & (diff_t[BLOCK-1] ^ as_t[BLOCK-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r    <= '0;
      bout_r <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        d_r[k] <= '0;
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (go[k]) begin
          v_r[k] <= src_v[k];
          // Data registers move only with a real operation. An empty slot
          // leaves them alone, so D holds its last value between results.
          if (src_v[k]) begin
            d_r[k]    <= nxt_d[k];
            a_r[k]    <= nxt_a[k];
            b_r[k]    <= nxt_b[k];
            bout_r[k] <= nxt_bout[k];
          end
        end
      end
    end
  end

`ifdef CS_SUB_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (go[NSTAGES-1] && src_v[NSTAGES-1]) begin
      ovf_r <= nxt_ovf;
    end
  end

  assign OVF = ovf_r;
`else
  // The top-slice overflow term has no consumer in this build.
  logic unused_ovf;
  assign unused_ovf = nxt_ovf;
`endif

  assign out_valid = v_r[NSTAGES-1];
  assign D         = d_r[NSTAGES-1];
  assign BOUT      = bout_r[NSTAGES-1];

endmodule

// File: tb/tb_cs_subtractor_pipe.sv
// Testbench for cs_subtractor_pipe (default WIDTH=8, BLOCK=4).
// Also builds with CS_SUB_OVF_EN defined, which enables the OVF checks.
module tb_cs_subtractor_pipe;

  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 2;   // {ovf, bout, d}

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef CS_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]  exp_q [$];
  logic [WIDTH:0] got_q [$];

  cs_subtractor_pipe #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .BIN       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (d),
    .BOUT      (bout)
`ifdef CS_SUB_OVF_EN
    ,
    .OVF       (ovf)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  // Plain integer arithmetic: the unsigned difference gives D and BOUT.
  // The signed difference, checked against the representable range, gives OVF.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] ma,
                                          input logic [WIDTH-1:0] mb,
                                          input logic             mbin);
    int full;
    int sdiff;
    logic [WIDTH-1:0] md;
    logic mbo;
    logic mo;
    full  = int'(ma) - int'(mb) - int'(mbin);
    mbo   = (full < 0);
    md    = full[WIDTH-1:0];
    sdiff = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    mo    = (sdiff < -(1 << (WIDTH - 1))) || (sdiff > (1 << (WIDTH - 1)) - 1);
    return {mo, mbo, md};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- scoreboard / compare ----------------
  // Sampled on the falling edge. What is seen here is what the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_d", d, 0);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got D=%0h, expected no result", d);
        end else begin
          check("model_d", d, exp_q[0][WIDTH-1:0]);
          check("model_bout", bout, exp_q[0][WIDTH]);
`ifdef CS_SUB_OVF_EN
          check("model_ovf", ovf, exp_q[0][WIDTH+1]);
`endif
          if (out_ready) begin
            got_q.push_back({bout, d});
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb, input logic sbin);
    bit ok;
    a        = sa;
    b        = sb;
    bin      = sbin;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) fail_now("send_accept");
    tick();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    bin      = 1'bx;
  endtask

  task automatic expect_out(input logic [WIDTH-1:0] ed, input logic ebo, input logic eovf,
                            input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      fail_now(name);
    end else begin
      check({name, "_d"}, d, ed);
      check({name, "_bout"}, bout, ebo);
`ifdef CS_SUB_OVF_EN
      check({name, "_ovf"}, ovf, eovf);
`else
      if (eovf !== 1'b0) check({name, "_ovf_arg"}, eovf, 0);
`endif
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] va [8] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h12, 8'hA5, 8'h0F, 8'hF0};
  logic [WIDTH-1:0] vb [8] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h21, 8'hA5, 8'hF0, 8'h0F};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    // Literal values that pin the model itself.
    check("pin_model_basic", model(8'h50, 8'h30, 1'b0), 10'h020);
    check("pin_model_under", model(8'h00, 8'h01, 1'b0), 10'h1FF);
    check("pin_model_ovf", model(8'h80, 8'h01, 1'b0), 10'h27F);
    check("pin_model_skip", model(8'h3C, 8'h3C, 1'b1), 10'h1FF);

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_d", d, 0);
    check("reset_bout", bout, 0);
    tick();

    // Basic subtract with a latency check: valid on the second edge after accept.
    send(8'h50, 8'h30, 1'b0);
    @(negedge clk);
    check("latency_early", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("basic_d", d, 8'h20);
    check("basic_bout", bout, 0);
    tick();

    send(8'h00, 8'h01, 1'b0);
    expect_out(8'hFF, 1'b1, 1'b0, "underflow");
    send(8'h3C, 8'h3C, 1'b1);
    expect_out(8'hFF, 1'b1, 1'b0, "skip_bin1");
    send(8'h3C, 8'h3C, 1'b0);
    expect_out(8'h00, 1'b0, 1'b0, "skip_bin0");

    // Backpressure: fill both stages, stall, then release.
    repeat (3) tick();
    got_q.delete();
    out_ready = 1'b0;
    send(8'd9, 8'd4, 1'b0);
    send(8'd200, 8'd100, 1'b0);
    a        = 8'd7;
    b        = 8'd9;
    bin      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_d", d, 8'd5);
    end
    tick();
    out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = in_ready;
      end
      if (!ok) fail_now("bp_release");
    end
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_res0", got_q[0], 9'h005);
      check("bp_res1", got_q[1], 9'h064);
      check("bp_res2", got_q[2], 9'h1FE);
    end

    // Reset with operations in flight.
    out_ready = 1'b0;
    send(8'h11, 8'h01, 1'b0);
    send(8'h22, 8'h02, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_d", d, 0);
    check("midrst_bout", bout, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_ghost", out_valid, 0);
    end
    tick();

`ifdef CS_SUB_OVF_EN
    send(8'h80, 8'h01, 1'b0);
    expect_out(8'h7F, 1'b0, 1'b1, "ovf_set");
    send(8'h10, 8'h01, 1'b0);
    expect_out(8'h0F, 1'b0, 1'b0, "ovf_clear");
`endif

    // Vector table under random backpressure; the scoreboard checks every result.
    fork
      begin
        for (int i = 0; i < 8; i++) send(va[i], vb[i], 1'($urandom_range(0, 1)));
        for (int i = 0; i < 8; i++) send(vb[i], va[i], 1'b1);
      end
      begin
        repeat (60) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_subtractor_pipe.md
Name: cs_subtractor_pipe

Overview:
- Pipelined carry-skip subtractor; the subtract-direction counterpart to the 8-bit carry-skip adder.
- Computes D = A - B - BIN one BLOCK-bit slice per pipeline stage.
- Each slice resolves its borrow with a borrow-skip path: when the slice operands are equal, the slice borrow-out is the incoming borrow.
- Valid/ready handshake on both sides; sits between operand producers and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 4, slice width, one slice per pipeline stage.
- NSTAGES, WIDTH/BLOCK, derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- BIN  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- D  output  WIDTH  difference
- BOUT  output  1  borrow out (1 = unsigned A < B + BIN)

Behaviour:
- Reset (async, active-high):
  - All stage valid bits clear; all data/borrow registers clear.
  - out_valid=0, D=0, BOUT=0.
  - in_ready=1 after reset.
- Transfer rules:
  - Accept on in_valid && in_ready; output handoff on out_valid && out_ready.
  - in_ready is combinational from stage-0 valid and downstream advance: in_ready = !v0 || advance0.
  - stage k advances when !v(k+1) || advance(k+1).
  - The last stage advances when out_ready.
- Stage k, slice bits [k*BLOCK +: BLOCK]:
  - diff_k = A_k - B_k - bin_k, modulo 2^BLOCK.
  - Skip condition: A_k == B_k. If true, bout_k = bin_k; otherwise bout_k = (A_k < B_k).
  - Borrow is implemented via the skip mux, not a ripple chain across slices.
- Stage registers:
  - Each stage registers the result slices computed so far, its borrow-out, and the remaining upper operand slices.
  - Consumed operand slices are not carried forward.
- Latency: NSTAGES cycles from accept to out_valid with no backpressure (2 for defaults).
- Throughput: one operation per cycle when out_ready is held high.
- Outputs: out_valid = last-stage valid; D and BOUT are direct last-stage registers, with no combinational path from A/B.
- Backpressure:
  - While out_ready=0, the full pipeline holds D/BOUT stable and deasserts in_ready.
  - No operation is dropped or duplicated; results emerge in acceptance order.
  - Bubbles collapse: an empty stage accepts from the stage behind it even while the output is stalled.
- Simultaneous accept and output handoff with a full pipeline: allowed; occupancy is unchanged.
- Wrap-around: D wraps modulo 2^WIDTH; BOUT=1 flags the wrap.
- Reset mid-operation: all in-flight operations are discarded. No result appears after reset deasserts unless new operands are accepted.
- Operands with X while in_valid=0 are don't-care; only accepted data is used.

Optional Feature:
- Macro CS_SUB_OVF_EN.
- When defined:
  - Adds output port OVF (1 bit).
  - OVF is the signed two's-complement overflow of A - B - BIN: operand MSBs differ and D MSB differs from A MSB.
  - OVF is registered alongside D/BOUT in the last stage, resets to 0, and is valid when out_valid.
- When undefined: no OVF port, no extra logic; the port list is exactly as above.

Test Plan:
- Basic subtract: A=8'h50, B=8'h30, BIN=0, out_ready=1 -> 2 cycles later out_valid=1, D=8'h20, BOUT=0.
- Underflow: A=8'h00, B=8'h01, BIN=0 -> D=8'hFF, BOUT=1.
- Full borrow-skip: A=8'h3C, B=8'h3C, BIN=1 -> both slices take the skip path; D=8'hFF, BOUT=1. Same operands with BIN=0 -> D=8'h00, BOUT=0.
- Backpressure: send (9,4), (200,100), (7,9) back-to-back, out_ready=0 for 4 cycles.
  - in_ready drops once both stages are full; outputs hold.
  - After release: D=5, 100, 8'hFE in that order, BOUT=0,0,1, no loss.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle before the first completes -> out_valid=0, D=0, BOUT=0 immediately; no output until new input.
- CS_SUB_OVF_EN build: A=8'h80, B=8'h01, BIN=0 -> D=8'h7F, OVF=1, BOUT=0. A=8'h10, B=8'h01 -> D=8'h0F, OVF=0.
